// File: rtl/tas_pkg.sv
// Shared types and constants for the temperature averaging block.
//   pkt_state_t : packet FSM states (hunt for header, accumulate, divide)
//   wr_state_t  : RAM write strobe sequencer states
//   TAS_HDR_A/B : default packet header values
package tas_pkg;

  typedef enum logic [1:0] {
    HUNT,
    ACCUM,
    DIVIDE
  } pkt_state_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } wr_state_t;

  localparam logic [7:0] TAS_HDR_A = 8'hA5;
  localparam logic [7:0] TAS_HDR_B = 8'hC3;

endpackage

// File: rtl/tas_s2p.sv
// Serial-to-parallel deserialiser, LSB first.
//   clk_50      : clock
//   reset       : asynchronous active-high reset
//   serial_data : serial bit, taken on every cycle with data_ena=1
//   data_ena    : bit qualifier; a low cycle mid-word discards the partial word
//   word        : assembled word, valid while word_valid=1
//   word_valid  : one-cycle pulse, the cycle after the last bit of a word
module tas_s2p #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              serial_data,
  input  logic              data_ena,
  output logic [DATA_W-1:0] word,
  output logic              word_valid
);

  localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = '0;
    valid_d = 1'b0;
    if (data_ena) begin
      shift_d = {serial_data, shift_q[DATA_W-1:1]};
      if (cnt_q == LAST_BIT) begin
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign word       = shift_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/tas_avg.sv
// Temperature averaging block: deserialises a serial byte stream, finds
// packets beginning with HDR_A or HDR_B, averages the next NUM_SAMPLES words
// and writes each average to RAM, walking down from the top address.
//   clk_50      : clock
//   reset       : asynchronous active-high reset
//   serial_data : serial bit input
//   data_ena    : serial bit qualifier
//   ram_wr_n    : active-low RAM write strobe, low for WR_PULSE cycles
//   ram_data    : average being written
//   ram_addr    : RAM write address
//   overflow    : sticky; an average was dropped because the buffer was full
module tas_avg
  import tas_pkg::*;
#(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       NUM_SAMPLES = 4,
  parameter int unsigned       ADDR_W      = 11,
  parameter logic [DATA_W-1:0] HDR_A       = DATA_W'(TAS_HDR_A),
  parameter logic [DATA_W-1:0] HDR_B       = DATA_W'(TAS_HDR_B),
  parameter int unsigned       WR_PULSE    = 2
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              serial_data,
  input  logic              data_ena,
  output logic              ram_wr_n,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              overflow
);

  localparam int unsigned SH     = $clog2(NUM_SAMPLES);
  localparam int unsigned ACC_W  = DATA_W + SH;
  localparam int unsigned SCNT_W = SH + 1;
  localparam int unsigned PCNT_W = $clog2(WR_PULSE) + 1;

  logic [DATA_W-1:0] word;
  logic              word_valid;

  tas_s2p #(.DATA_W(DATA_W)) u_s2p (
    .clk_50      (clk_50),
    .reset       (reset),
    .serial_data (serial_data),
    .data_ena    (data_ena),
    .word        (word),
    .word_valid  (word_valid)
  );

  pkt_state_t        pkt_q, pkt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              ovf_q, ovf_d;
  wr_state_t         wr_q, wr_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              wr_n_q, wr_n_d;
  logic              push, pop;
  logic [DATA_W-1:0] avg;

  assign avg = acc_q[ACC_W-1:SH];
  assign pop = (wr_q == IDLE) && buf_full_q;

  // Packet FSM
  always_comb begin
    pkt_d  = pkt_q;
    acc_d  = acc_q;
    scnt_d = scnt_q;
    push   = 1'b0;
    case (pkt_q)
      HUNT: begin
        if (word_valid && ((word == HDR_A) || (word == HDR_B))) begin
          acc_d  = '0;
          scnt_d = '0;
          pkt_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (word_valid) begin
          acc_d  = acc_q + ACC_W'(word);
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == SCNT_W'(NUM_SAMPLES - 1)) pkt_d = DIVIDE;
        end
      end
      DIVIDE: begin
        push  = 1'b1;
        pkt_d = HUNT;
      end
      default: pkt_d = HUNT;
    endcase
  end

  // Result buffer: a push coinciding with the write FSM's pop is accepted,
  // since the slot is being vacated on that same edge.
  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    ovf_d      = ovf_q;
    if (pop) buf_full_d = 1'b0;
    if (push) begin
      if (buf_full_q && !pop) begin
        ovf_d = 1'b1;
      end else begin
        buf_d      = avg;
        buf_full_d = 1'b1;
      end
    end
  end

  // RAM write sequencer
  always_comb begin
    wr_d        = wr_q;
    pcnt_d      = pcnt_q;
    ram_data_d  = ram_data_q;
    ram_addr_d  = ram_addr_q;
    next_addr_d = next_addr_q;
    case (wr_q)
      IDLE: begin
        if (buf_full_q) begin
          ram_data_d = buf_q;
          ram_addr_d = next_addr_q;
          pcnt_d     = '0;
          wr_d       = SETUP;
        end
      end
      SETUP: wr_d = STROBE;
      STROBE: begin
        if (pcnt_q == PCNT_W'(WR_PULSE - 1)) begin
          wr_d = HOLD;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      HOLD: begin
        next_addr_d = next_addr_q - 1'b1;
        wr_d        = IDLE;
      end
      default: wr_d = IDLE;
    endcase
    wr_n_d = (wr_d != STROBE);
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      pkt_q       <= HUNT;
      acc_q       <= '0;
      scnt_q      <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      ovf_q       <= 1'b0;
      wr_q        <= IDLE;
      pcnt_q      <= '0;
      ram_data_q  <= '0;
      ram_addr_q  <= '1;
      next_addr_q <= '1;
      wr_n_q      <= 1'b1;
    end else begin
      pkt_q       <= pkt_d;
      acc_q       <= acc_d;
      scnt_q      <= scnt_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      ovf_q       <= ovf_d;
      wr_q        <= wr_d;
      pcnt_q      <= pcnt_d;
      ram_data_q  <= ram_data_d;
      ram_addr_q  <= ram_addr_d;
      next_addr_q <= next_addr_d;
      wr_n_q      <= wr_n_d;
    end
  end

  assign ram_wr_n = wr_n_q;
  assign ram_data = ram_data_q;
  assign ram_addr = ram_addr_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_tas_avg.sv
// Directed bench for tas_avg. Three instances share one stimulus stream:
// default parameters, a 64-cycle write strobe, and a 16-entry address space
// (the address wrap exercised with 17 packets instead of 2049).
module tb_tas_avg;

  typedef struct {
    logic [7:0]  d;
    logic [10:0] a;
    int          len;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic serial_data = 1'b0;
  logic data_ena = 1'b0;

  logic        wr_n1, ovf1, wr_n2, ovf2, wr_n3, ovf3;
  logic [7:0]  data1, data2, data3;
  logic [10:0] addr1, addr2;
  logic [3:0]  addr3;

  int tot = 0;
  int fails = 0;

  wr_t q1[$];
  wr_t q2[$];
  wr_t q3[$];
  wr_t cur1;
  logic prev1 = 1'b1;
  logic prev2 = 1'b1;
  logic prev3 = 1'b1;

  always #5 clk = ~clk;

  tas_avg u_main (
    .clk_50(clk), .reset(rst), .serial_data(serial_data), .data_ena(data_ena),
    .ram_wr_n(wr_n1), .ram_data(data1), .ram_addr(addr1), .overflow(ovf1)
  );

  tas_avg #(.WR_PULSE(64)) u_slow (
    .clk_50(clk), .reset(rst), .serial_data(serial_data), .data_ena(data_ena),
    .ram_wr_n(wr_n2), .ram_data(data2), .ram_addr(addr2), .overflow(ovf2)
  );

  tas_avg #(.ADDR_W(4)) u_small (
    .clk_50(clk), .reset(rst), .serial_data(serial_data), .data_ena(data_ena),
    .ram_wr_n(wr_n3), .ram_data(data3), .ram_addr(addr3), .overflow(ovf3)
  );

  // Write monitors: record data/address at the falling strobe edge,
  // and for the main instance also the strobe length in cycles.
  always @(negedge clk) begin
    if (rst) begin
      prev1 <= 1'b1;
    end else begin
      if (!wr_n1 && prev1) begin
        cur1.d   <= data1;
        cur1.a   <= addr1;
        cur1.len <= 1;
      end else if (!wr_n1) begin
        cur1.len <= cur1.len + 1;
      end else if (!prev1) begin
        q1.push_back(cur1);
      end
      prev1 <= wr_n1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev2 <= 1'b1;
      prev3 <= 1'b1;
    end else begin
      if (!wr_n2 && prev2) q2.push_back('{data2, addr2, 0});
      if (!wr_n3 && prev3) q3.push_back('{data3, {7'd0, addr3}, 0});
      prev2 <= wr_n2;
      prev3 <= wr_n3;
    end
  end

  function automatic logic [31:0] fld(int unsigned qi, int unsigned i, int unsigned f);
    wr_t e;
    if (qi == 1 && i < q1.size()) e = q1[i];
    else if (qi == 2 && i < q2.size()) e = q2[i];
    else if (qi == 3 && i < q3.size()) e = q3[i];
    else return 32'hFFFF_FFFF;
    case (f)
      0:       return 32'(e.d);
      1:       return 32'(e.a);
      default: return 32'(e.len);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      data_ena    = 1'b1;
      serial_data = b[i];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_ena    = 1'b0;
      serial_data = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    send_byte(h);
    send_byte(a);
    send_byte(b);
    send_byte(c);
    send_byte(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    data_ena = 1'b0;
    rst      = 1'b1;
    repeat (2) @(negedge clk);
    q1.delete();
    q2.delete();
    q3.delete();
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_n", 32'(wr_n1), 32'd1);
    chk("rst_data", 32'(data1), 32'd0);
    chk("rst_addr", 32'(addr1), 32'h7FF);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    rst = 1'b0;

    // Single A5 packet: (10+20+30+40)>>2 = 25
    send_pkt(8'hA5, 8'd10, 8'd20, 8'd30, 8'd40);
    idle(20);
    chk("t1_nwr", 32'(q1.size()), 32'd1);
    chk("t1_data", fld(1, 0, 0), 32'd25);
    chk("t1_addr", fld(1, 0, 1), 32'h7FF);
    chk("t1_len", fld(1, 0, 2), 32'd2);
    chk("t1_ovf", 32'(ovf1), 32'd0);
    chk("t1_hold_data", 32'(data1), 32'd25);
    chk("t1_hold_addr", 32'(addr1), 32'h7FF);

    // Back-to-back C3 packets: 8 then 11>>2 = 2
    do_reset();
    send_pkt(8'hC3, 8'd8, 8'd8, 8'd8, 8'd8);
    send_pkt(8'hC3, 8'd1, 8'd2, 8'd3, 8'd5);
    idle(20);
    chk("t2_nwr", 32'(q1.size()), 32'd2);
    chk("t2_data0", fld(1, 0, 0), 32'd8);
    chk("t2_addr0", fld(1, 0, 1), 32'h7FF);
    chk("t2_data1", fld(1, 1, 0), 32'd2);
    chk("t2_addr1", fld(1, 1, 1), 32'h7FE);
    chk("t2_len1", fld(1, 1, 2), 32'd2);

    // Non-header bytes ignored while hunting
    do_reset();
    send_byte(8'h11);
    send_byte(8'hFF);
    send_pkt(8'hA5, 8'd4, 8'd4, 8'd4, 8'd4);
    idle(20);
    chk("t3_nwr", 32'(q1.size()), 32'd1);
    chk("t3_data", fld(1, 0, 0), 32'd4);
    chk("t3_addr", fld(1, 0, 1), 32'h7FF);

    // Partial word (5 bits of FF) dropped by a data_ena gap
    do_reset();
    send_byte(8'hA5);
    send_byte(8'd10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_ena    = 1'b1;
      serial_data = 1'b1;
    end
    idle(1);
    send_byte(8'd20);
    send_byte(8'd30);
    send_byte(8'd40);
    idle(20);
    chk("t4_nwr", 32'(q1.size()), 32'd1);
    chk("t4_data", fld(1, 0, 0), 32'd25);

    // Address wrap on the 16-entry instance: write 16 at 0, write 17 at 0xF
    do_reset();
    for (int p = 1; p <= 17; p++) begin
      send_pkt(8'hA5, 8'(p), 8'(p), 8'(p), 8'(p));
    end
    idle(20);
    chk("t5_nwr", 32'(q3.size()), 32'd17);
    chk("t5_addr_first", fld(3, 0, 1), 32'hF);
    chk("t5_data16", fld(3, 15, 0), 32'd16);
    chk("t5_addr16", fld(3, 15, 1), 32'h0);
    chk("t5_data17", fld(3, 16, 0), 32'd17);
    chk("t5_addr17", fld(3, 16, 1), 32'hF);

    // Long strobe: four packets at full rate, the fourth average is dropped
    do_reset();
    for (int p = 1; p <= 4; p++) begin
      send_pkt(8'hA5, 8'(p), 8'(p), 8'(p), 8'(p));
    end
    idle(300);
    chk("t6_ovf", 32'(ovf2), 32'd1);
    chk("t6_nwr", 32'(q2.size()), 32'd3);
    chk("t6_data0", fld(2, 0, 0), 32'd1);
    chk("t6_data1", fld(2, 1, 0), 32'd2);
    chk("t6_data2", fld(2, 2, 0), 32'd3);
    chk("t6_addr2", fld(2, 2, 1), 32'h7FD);
    chk("t6_main_ovf", 32'(ovf1), 32'd0);
    chk("t6_main_nwr", 32'(q1.size()), 32'd4);

    // Reset in the middle of a long strobe
    send_pkt(8'hC3, 8'd9, 8'd9, 8'd9, 8'd9);
    waited = 0;
    while (wr_n2 !== 1'b0 && waited < 100) begin
      idle(1);
      waited++;
    end
    repeat (10) @(negedge clk);
    chk("t7_in_strobe", 32'(wr_n2), 32'd0);
    chk("t7_pre_data", 32'(data2), 32'd9);
    rst = 1'b1;
    #1;
    chk("t7_wr_n", 32'(wr_n2), 32'd1);
    chk("t7_data", 32'(data2), 32'd0);
    chk("t7_addr", 32'(addr2), 32'h7FF);
    chk("t7_ovf", 32'(ovf2), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", tot, fails);
    $finish;
  end

endmodule

// File: doc/tas_avg.md
Name: tas_avg

Overview:
- Parametrised successor to the temperature averaging system block.
- Deserialises an LSB-first serial byte stream and detects packets that start with either of two header bytes.
- Accumulates NUM_SAMPLES data words per packet, divides by shifting, and writes each average to RAM, walking downward from the top address.
- Sits between the serial sensor front end and the 2^ADDR_W-entry result RAM, all in one clock domain.

Parameters:
- DATA_W, 8, serial word width in bits.
- NUM_SAMPLES, 4, data words averaged per packet; must be a power of 2 and at least 2.
- ADDR_W, 11, RAM address width.
- HDR_A, 8'hA5, first valid header value (DATA_W bits).
- HDR_B, 8'hC3, second valid header value (DATA_W bits).
- WR_PULSE, 2, number of cycles ram_wr_n is held low; at least 1.

Ports:
- clk_50  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- serial_data  in  1  serial bit, sampled each cycle that data_ena=1.
- data_ena  in  1  qualifies serial_data; one bit is taken per enabled cycle.
- ram_wr_n  out  1  active-low RAM write strobe.
- ram_data  out  DATA_W  average being written.
- ram_addr  out  ADDR_W  RAM write address.
- overflow  out  1  sticky flag: an average was dropped because the write path was busy.

Behaviour:
- Reset values: ram_wr_n=1, ram_data=0, ram_addr=all ones, overflow=0. The bit counter, accumulator, sample counter and all FSMs return to their idle states; the next write address returns to all ones.
- Reset asserted mid-operation aborts any partial byte, packet or write immediately; ram_wr_n returns to 1 asynchronously.
- Deserialiser:
  - The shift register shifts right each data_ena cycle, with serial_data entering the MSB, so the first bit received is the LSB.
  - After DATA_W enabled bits, word_valid pulses for 1 cycle with the word. Latency: one cycle after the last enabled bit.
  - A data_ena low cycle inside a word discards the partial word and clears the bit counter (no gaps allowed).
- Packet FSM, states HUNT -> ACCUM -> DIVIDE -> HUNT:
  - HUNT: on word_valid with word==HDR_A or HDR_B, clear the accumulator and sample count and go to ACCUM. Any other word is ignored.
  - ACCUM: on each word_valid, add the word to the accumulator and increment the sample count. Header values are treated as data here. When the count reaches NUM_SAMPLES, go to DIVIDE.
  - DIVIDE: one cycle. avg = acc >> $clog2(NUM_SAMPLES), truncating. Push avg into the 1-entry result buffer, then return to HUNT.
- Accumulator width is DATA_W+$clog2(NUM_SAMPLES), so it cannot overflow. avg always fits in DATA_W bits.
- Result buffer and overflow:
  - If the buffer is still full when DIVIDE pushes, the new average is dropped and overflow is set.
  - overflow is cleared only by reset.
- RAM write FSM, states IDLE -> SETUP -> STROBE -> HOLD -> IDLE:
  - IDLE: when the buffer is full, load ram_data and ram_addr, pop the buffer, and go to SETUP.
  - SETUP: 1 cycle; ram_wr_n stays 1.
  - STROBE: ram_wr_n=0 for WR_PULSE cycles.
  - HOLD: 1 cycle with ram_wr_n=1; data and address stay stable. Then decrement the next address and return to IDLE.
  - ram_data and ram_addr hold their last values while IDLE.
- Address wrap: after writing address 0, the next write goes to all ones (2^ADDR_W-1).
- Simultaneous events: a new byte may be deserialised while a write is in progress; packet reception never stalls.
- A header word arriving in DIVIDE is ignored, since DIVIDE lasts one cycle and no word_valid can occur then when DATA_W≥2.

Decomposition:
- Package tas_pkg holds:
  - enums pkt_state_t {HUNT, ACCUM, DIVIDE} and wr_state_t {IDLE, SETUP, STROBE, HOLD};
  - default header constants TAS_HDR_A=8'hA5 and TAS_HDR_B=8'hC3.
- One sub-module, tas_s2p (parameter DATA_W): ports clk_50, reset, serial_data, data_ena, word[DATA_W-1:0], word_valid.
- The packet FSM, result buffer and write FSM stay in tas_avg.

Test Plan:
- Reset, then send header A5 followed by 10,20,30,40 -> ram_wr_n pulses low for 2 cycles with ram_addr=0x7FF and ram_data=25 (sum 100>>2); overflow=0.
- Two back-to-back C3 packets (8,8,8,8 then 1,2,3,5) -> writes 8 at 0x7FF, then 2 at 0x7FE; the second result truncates 11/4 to 2.
- Byte 0x11, then 0xFF, then header A5 + 4,4,4,4 -> non-header bytes ignored; exactly one write of 4.
- data_ena dropped after 5 bits of a data word, then a full word resent -> partial word discarded; average uses only the complete words.
- Run 2049 packets of value v -> the 2048th write goes to address 0, the 2049th wraps to 0x7FF.
- WR_PULSE=64 with packets sent back-to-back at full rate -> overflow=1 and the excess average is not written; assert reset during STROBE -> ram_wr_n=1 immediately and all outputs at reset values.
